nx_ram_1r1w_init: RTL and testbench



---
 rtl/nx_ram_pkg.sv | 23 ++
 rtl/nx_ram_init_fsm.sv | 67 ++++++
 rtl/nx_ram_1r1w_init.sv | 99 +++++++++
 tb/tb_nx_ram_1r1w_init.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/nx_ram_pkg.sv
// Shared types and helpers for the nx_ram family: init FSM states and
// byte-enable lane expansion.
package nx_ram_pkg;

    typedef enum logic [1:0] {RAM_RESET, RAM_INIT, RAM_READY} nx_ram_init_e;

    // Upper bound on data width handled by the lane expansion helper.
    localparam int NX_MAX_W = 1024;

    // Expand per-lane enables into a per-bit mask; lane k covers bits [k*lane_w +: lane_w].
    function automatic logic [NX_MAX_W-1:0] nx_bwe_expand(input logic [NX_MAX_W-1:0] bwe,
                                                          input int lane_w);
        logic [NX_MAX_W-1:0] m;
        logic [9:0]          lane;
        m = '0;
        for (int i = 0; i < NX_MAX_W; i++) begin
            lane = 10'(i / lane_w);
            m[i] = bwe[lane];
        end
        return m;
    endfunction

endpackage

// File: rtl/nx_ram_init_fsm.sv
// Init engine: walks every address once writing the fill value, gates
// external traffic until done and flags accesses dropped meanwhile.
module nx_ram_init_fsm
    import nx_ram_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter bit INIT_ON_RESET = 1'b1,
    parameter int AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          reb,
    input  logic          web,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic          init_done,
    output logic          access_err
);

    nx_ram_init_e  state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            RAM_RESET: begin
                state_d = INIT_ON_RESET ? RAM_INIT : RAM_READY;
                cnt_d   = '0;
            end
            RAM_INIT: begin
                init_we = 1'b1;
                if (clr)
                    cnt_d = '0;
                else if (cnt_q == AW'(DEPTH - 1))
                    state_d = RAM_READY;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            RAM_READY: begin
                if (clr) begin
                    state_d = RAM_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = RAM_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RAM_RESET;
            cnt_q      <= '0;
            access_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            access_err <= (state_q != RAM_READY) && (!reb || !web);
        end
    end

    assign init_addr = cnt_q;
    assign init_done = (state_q == RAM_READY);

endmodule

// File: rtl/nx_ram_1r1w_init.sv
// 1R1W synchronous RAM with lane-masked writes, configurable read pipeline
// and a hardware fill engine that runs after reset or on clr.
module nx_ram_1r1w_init
    import nx_ram_pkg::*;
#(
    parameter int               WIDTH         = 64,
    parameter int               DEPTH         = 256,
    parameter int               BWEWIDTH      = 8,
    parameter int               RD_LATENCY    = 1,
    parameter int               OUT_FLOP      = 0,
    parameter bit               WRITETHROUGH  = 1'b0,
    parameter bit               INIT_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       reb,
    input  logic [$clog2(DEPTH)-1:0]   ra,
    input  logic                       web,
    input  logic [$clog2(DEPTH)-1:0]   wa,
    input  logic [WIDTH-1:0]           din,
    input  logic [BWEWIDTH-1:0]        bwe,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    output logic                       init_done,
    output logic                       access_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int G      = WIDTH / BWEWIDTH;
    localparam int STAGES = RD_LATENCY + OUT_FLOP;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic                init_we;
    logic [AW-1:0]       init_addr;
    logic                wr_en, rd_en;
    logic [NX_MAX_W-1:0] bwe_ext;
    logic [WIDTH-1:0]    mask, wr_word, rd_word;
    logic [STAGES:1]     vld_pipe;
    logic [WIDTH-1:0]    dat_pipe [1:STAGES];

    nx_ram_init_fsm #(
        .DEPTH        (DEPTH),
        .INIT_ON_RESET(INIT_ON_RESET),
        .AW           (AW)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .reb       (reb),
        .web       (web),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_done (init_done),
        .access_err(access_err)
    );

    always_comb begin
        bwe_ext                 = '0;
        bwe_ext[BWEWIDTH-1:0]   = bwe;
    end

    assign mask    = WIDTH'(nx_bwe_expand(bwe_ext, G));
    assign wr_en   = init_done && !web;
    assign rd_en   = init_done && !reb;
    assign wr_word = (mem[wa] & ~mask) | (din & mask);
    // Write-through forwards the merged word so a colliding read sees it this cycle.
    assign rd_word = (WRITETHROUGH && wr_en && (wa == ra)) ? wr_word : mem[ra];

    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= INIT_VALUE;
        else if (wr_en)
            mem[wa] <= wr_word;
    end

    // Data stages only advance with their valid so dout holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= STAGES; i++)
                dat_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            if (rd_en)
                dat_pipe[1] <= rd_word;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1])
                    dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign dout     = dat_pipe[STAGES];
    assign dout_vld = vld_pipe[STAGES];

endmodule

// File: tb/tb_nx_ram_1r1w_init.sv
// Directed bench: two instances share stimulus, one (A5 fill, latency 1, no
// write-through) and one (zero fill, latency 3+1, write-through).
module tb_nx_ram_1r1w_init;

    typedef struct {
        int          c;
        logic [31:0] d;
    } ent_t;

    localparam logic [31:0] IV0 = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        reb = 1'b1;
    logic        web = 1'b1;
    logic [3:0]  ra  = '0;
    logic [3:0]  wa  = '0;
    logic [3:0]  bwe = '0;
    logic [31:0] din = '0;
    logic [31:0] dout0, dout1;
    logic        vld0, vld1, done0, done1, err0, err1;

    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;
    ent_t q0[$], q1[$], e0[$], e1[$];

    nx_ram_1r1w_init #(
        .WIDTH(32), .DEPTH(16), .BWEWIDTH(4), .RD_LATENCY(1), .OUT_FLOP(0),
        .WRITETHROUGH(1'b0), .INIT_ON_RESET(1'b1), .INIT_VALUE(IV0)
    ) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .reb(reb), .ra(ra), .web(web), .wa(wa),
        .din(din), .bwe(bwe), .dout(dout0), .dout_vld(vld0), .init_done(done0),
        .access_err(err0)
    );

    nx_ram_1r1w_init #(
        .WIDTH(32), .DEPTH(16), .BWEWIDTH(4), .RD_LATENCY(3), .OUT_FLOP(1),
        .WRITETHROUGH(1'b1), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0)
    ) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .reb(reb), .ra(ra), .web(web), .wa(wa),
        .din(din), .bwe(bwe), .dout(dout1), .dout_vld(vld1), .init_done(done1),
        .access_err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld0) q0.push_back('{cyc, dout0});
        if (vld1) q1.push_back('{cyc, dout1});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic; accepted reads queue their expected arrival.
    task automatic op(input bit r, input logic [3:0] a_r, input bit w, input logic [3:0] a_w,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] x0, input logic [31:0] x1);
        reb = !r; ra = a_r; web = !w; wa = a_w; din = d; bwe = be;
        if (r) begin
            e0.push_back('{cyc + 1, x0});
            e1.push_back('{cyc + 4, x1});
        end
        tick();
        reb = 1'b1; web = 1'b1; bwe = '0;
    endtask

    task automatic drain();
        repeat (6) tick();
        chk("vld_count0", 32'(q0.size()), 32'(e0.size()));
        chk("vld_count1", 32'(q1.size()), 32'(e1.size()));
        for (int i = 0; i < e0.size() && i < q0.size(); i++) begin
            chk("rd_cycle0", 32'(q0[i].c), 32'(e0[i].c));
            chk("rd_data0", q0[i].d, e0[i].d);
        end
        for (int i = 0; i < e1.size() && i < q1.size(); i++) begin
            chk("rd_cycle1", 32'(q1[i].c), 32'(e1[i].c));
            chk("rd_data1", q1[i].d, e1[i].d);
        end
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
    endtask

    task automatic chk_rst();
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_vld", {30'b0, vld1, vld0}, 32'h0);
        chk("rst_done", {30'b0, done1, done0}, 32'h0);
        chk("rst_err", {30'b0, err1, err0}, 32'h0);
    endtask

    // Release reset; init_done must be low after edge 16 and high after edge 17.
    task automatic init_seq();
        rst = 1'b0;
        repeat (16) tick();
        chk("done_early", {30'b0, done1, done0}, 32'h0);
        tick();
        chk("done_rise", {30'b0, done1, done0}, 32'h3);
    endtask

    initial begin
        repeat (3) tick();
        chk_rst();
        init_seq();

        // full sweep back-to-back
        for (int a = 0; a < 16; a++) op(1'b1, 4'(a), 1'b0, 4'h0, 32'h0, 4'h0, IV0, 32'h0);
        drain();

        // lane masking and empty mask
        op(1'b0, 4'h0, 1'b1, 4'h3, 32'h1122_3344, 4'b0101, 32'h0, 32'h0);
        op(1'b1, 4'h3, 1'b0, 4'h0, 32'h0, 4'h0, 32'hA522_A544, 32'h0022_0044);
        op(1'b0, 4'h0, 1'b1, 4'h3, 32'hFFFF_FFFF, 4'b0000, 32'h0, 32'h0);
        op(1'b1, 4'h3, 1'b0, 4'h0, 32'h0, 4'h0, 32'hA522_A544, 32'h0022_0044);

        // same-address collision over old value 0
        op(1'b0, 4'h0, 1'b1, 4'h5, 32'h0, 4'hF, 32'h0, 32'h0);
        op(1'b1, 4'h5, 1'b1, 4'h5, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF);
        op(1'b1, 4'h5, 1'b0, 4'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        drain();

        // clr with a read already in flight, then a dropped access
        op(1'b1, 4'h3, 1'b0, 4'h0, 32'h0, 4'h0, 32'hA522_A544, 32'h0022_0044);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_done", {30'b0, done1, done0}, 32'h0);
        reb = 1'b0; ra = 4'h2; web = 1'b0; wa = 4'h2; din = 32'h1234_5678; bwe = 4'hF;
        tick();
        reb = 1'b1; web = 1'b1; bwe = '0;
        chk("err_pulse", {30'b0, err1, err0}, 32'h3);
        tick();
        chk("err_clear", {30'b0, err1, err0}, 32'h0);
        for (int i = 0; i < 40; i++) if (!(done0 && done1)) tick();
        chk("reinit_done", {30'b0, done1, done0}, 32'h3);
        op(1'b1, 4'h2, 1'b0, 4'h0, 32'h0, 4'h0, IV0, 32'h0);
        op(1'b1, 4'h3, 1'b0, 4'h0, 32'h0, 4'h0, IV0, 32'h0);
        op(1'b1, 4'h5, 1'b0, 4'h0, 32'h0, 4'h0, IV0, 32'h0);
        drain();

        // reset at cnt=7 with a pending access_err
        chk("dout_pre", dout0, IV0);
        clr = 1'b1;
        tick();
        clr = 1'b0; web = 1'b0; wa = 4'h0; bwe = 4'hF;
        repeat (7) tick();
        chk("err_init", {30'b0, err1, err0}, 32'h3);
        web = 1'b1; bwe = '0;
        #1 rst = 1'b1;
        #1 chk_rst();
        tick();
        tick();
        init_seq();
        op(1'b1, 4'h2, 1'b0, 4'h0, 32'h0, 4'h0, IV0, 32'h0);
        op(1'b1, 4'h5, 1'b0, 4'h0, 32'h0, 4'h0, IV0, 32'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
